imem_loader: RTL

Boot-time program loader: the write side of the CPU's instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. It holds the CPU in reset until the image is complete. It sits between the external download link and the instruction memory's write port, and drives the CPU core's reset.

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream download link into the instruction-memory loader.
// master = external link (drives data/valid), slave = loader (drives ready).
interface imem_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input  byte_ready);
    modport slave  (input  byte_data, input  byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives a length-prefixed byte
// stream, assembles big-endian 32-bit words, writes them to consecutive
// instruction-memory word addresses and holds the CPU in reset until the
// image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte covering the length and data bytes.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    imem_loader_if.slave        bus,
    input  logic                reload_i,
    output logic                wr_en_o,
    output logic [31:0]         wr_addr_o,
    output logic [31:0]         wr_data_o,
    output logic                cpu_rst_o,
    output logic                done_o,
    output logic                error_o
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        done_q;
    logic        error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accepting;
    logic        hs;
    logic [15:0] len_d;
    logic        last_word;

    // Ready is gated by rst_i so a byte offered during reset is never consumed.
    assign accepting      = (state_q != S_DONE) && (state_q != S_ERR);
    assign bus.byte_ready = accepting & ~rst_i;
    assign hs             = bus.byte_valid & bus.byte_ready;
    assign len_d          = {len_q[15:8], bus.byte_data};
    assign last_word      = (word_cnt_q == (len_q - 16'd1));

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign cpu_rst_o = ~done_q;

    // Loader FSM: length header, word assembly, optional checksum, terminal states.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_LEN_HI;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Running XOR over header and data bytes; the checksum byte itself is excluded.
            if (hs && (state_q != S_CSUM))
                csum_q <= csum_q ^ bus.byte_data;
`endif
            case (state_q)
                S_LEN_HI: begin
                    if (hs) begin
                        len_q   <= {bus.byte_data, 8'h00};
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (hs) begin
                        len_q <= len_d;
                        if ({1'b0, len_d} > MAX_LEN) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Fourth byte completes the word; strobe it next cycle.
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= {shift_q, bus.byte_data};
                            wr_addr_q  <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                            word_cnt_q <= word_cnt_q + 16'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], bus.byte_data};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (hs) begin
                        if (bus.byte_data == csum_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    // Restart keeps the last written address/data visible on the bus.
                    if (reload_i) begin
                        state_q    <= S_LEN_HI;
                        len_q      <= '0;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        shift_q    <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                default: state_q <= S_LEN_HI;
            endcase
        end
    end

endmodule
